// File: rtl/tawas_regfile_mt.sv
`default_nettype none
// ============================================================================
// Module   : tawas_regfile_mt
// Purpose  : Multi-thread register file for the Tawas core. Holds THREADS
//            contexts of NREGS words plus a flags field. Serves whole-context
//            captures to the issue stage. Merges up to WB_PORTS core
//            writebacks and one delayed external (RCN) load per cycle with
//            fixed collision priority. Includes read-after-write forwarding
//            and a post-reset clear sequencer.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            init_done           - contexts cleared, block operational
//            thread_load_en/thread_load -> regs, au_flags (1-cycle capture)
//            wb_thread, wb_en, wb_reg, wb_data, wb_flags_en, wb_flags
//                                - core writeback ports (all hit wb_thread)
//            ld_valid/ld_ready, ld_thread, ld_reg, ld_data
//                                - external load channel (valid/ready)
//            wb_conflict         - two or more sources hit one register
// Revision : 1.0 - initial release
// ============================================================================
module tawas_regfile_mt #(
  parameter  int THREADS  = 32,
  parameter  int NREGS    = 8,
  parameter  int DW       = 32,
  parameter  int FW       = 8,
  parameter  int WB_PORTS = 3,
  parameter  int LD_DELAY = 2,
  localparam int TW       = $clog2(THREADS),
  localparam int RW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  input  logic                   thread_load_en,
  input  logic [TW-1:0]          thread_load,
  output logic [NREGS*DW-1:0]    regs,
  output logic [FW-1:0]          au_flags,
  input  logic [TW-1:0]          wb_thread,
  input  logic [WB_PORTS-1:0]    wb_en,
  input  logic [WB_PORTS*RW-1:0] wb_reg,
  input  logic [WB_PORTS*DW-1:0] wb_data,
  input  logic                   wb_flags_en,
  input  logic [FW-1:0]          wb_flags,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [TW-1:0]          ld_thread,
  input  logic [RW-1:0]          ld_reg,
  input  logic [DW-1:0]          ld_data,
  output logic                   wb_conflict
);

  // Context word layout: registers in the low NREGS*DW bits, flags on top.
  localparam int CW = NREGS*DW + FW;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [0:0]          state_q, state_d;
  logic [TW-1:0]       clr_cnt_q, clr_cnt_d;
  logic                run;

  logic [CW-1:0]       ctx_q [THREADS];

  // Load delay pipeline; the last stage is the merge point.
  logic [LD_DELAY-1:0]         ld_v_q;
  logic [LD_DELAY-1:0][TW-1:0] ld_t_q;
  logic [LD_DELAY-1:0][RW-1:0] ld_r_q;
  logic [LD_DELAY-1:0][DW-1:0] ld_d_q;
  logic                        pv_out;
  logic [TW-1:0]               pt_out;
  logic [RW-1:0]               pr_out;
  logic [DW-1:0]               pd_out;

  // Single-entry hold for loads displaced by core traffic.
  logic                hold_v_q, hold_v_d;
  logic [TW-1:0]       hold_t_q;
  logic [RW-1:0]       hold_r_q;
  logic [DW-1:0]       hold_d_q;

  // Commit stage.
  logic                cv_q, cv_d;
  logic [TW-1:0]       ca_q, ca_d;
  logic [CW-1:0]       cd_q, cd_d;
  logic [CW-1:0]       cm_q, cm_d;

  // Capture path.
  logic [CW-1:0]       rd_q;
  logic [CW-1:0]       rd_raw;
  logic [CW-1:0]       rd_fwd;

  // Merge control.
  logic [WB_PORTS-1:0] core_en;
  logic                flags_en;
  logic                core_act;
  logic                accept;
  logic                hold_commit;
  logic                ld_alone;
  logic                ld_merge;
  logic                to_hold;
  logic                pipe_adv;
  logic                conflict;
  logic [NREGS-1:0]    hit;
  logic [RW-1:0]       lsel_reg;
  logic [DW-1:0]       lsel_data;

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  assign run       = (state_q == ST_RUN);
  assign init_done = run;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_INIT) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == TW'(THREADS - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Source qualification
  // --------------------------------------------------------------------------
  assign core_en  = run ? wb_en : '0;
  assign flags_en = run & wb_flags_en;
  assign core_act = (|core_en) | flags_en;

  assign ld_ready = run & ~hold_v_q;
  assign accept   = ld_valid & ld_ready;

  assign pv_out = ld_v_q[LD_DELAY-1];
  assign pt_out = ld_t_q[LD_DELAY-1];
  assign pr_out = ld_r_q[LD_DELAY-1];
  assign pd_out = ld_d_q[LD_DELAY-1];

  // --------------------------------------------------------------------------
  // Load routing.
  // While the hold is occupied it owns the next load commit slot, so any load
  // reaching the merge point waits in the pipeline (ld_ready is low, so
  // nothing new can enter behind it). This keeps loads in acceptance order
  // and means the single hold entry can never be overrun.
  // --------------------------------------------------------------------------
  always_comb begin
    hold_commit = 1'b0;
    ld_alone    = 1'b0;
    ld_merge    = 1'b0;
    to_hold     = 1'b0;
    pipe_adv    = 1'b1;
    if (hold_v_q) begin
      if (!core_act) begin
        hold_commit = 1'b1;
        to_hold     = pv_out;
      end else begin
        pipe_adv = ~pv_out;
      end
    end else if (pv_out) begin
      if (!core_act) begin
        ld_alone = 1'b1;
      end else if (pt_out == wb_thread) begin
        ld_merge = 1'b1;
      end else begin
        to_hold = 1'b1;
      end
    end
  end

  assign lsel_reg  = hold_commit ? hold_r_q : pr_out;
  assign lsel_data = hold_commit ? hold_d_q : pd_out;

  // --------------------------------------------------------------------------
  // Merge: ports are visited in ascending order so the lowest index claims a
  // register first; the load is visited last so every core port beats it.
  // --------------------------------------------------------------------------
  always_comb begin
    hit      = '0;
    cd_d     = '0;
    cm_d     = '0;
    conflict = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (core_en[p]) begin
        for (int r = 0; r < NREGS; r++) begin
          if (wb_reg[p*RW +: RW] == RW'(r)) begin
            if (hit[r]) begin
              conflict = 1'b1;
            end else begin
              hit[r]            = 1'b1;
              cd_d[r*DW +: DW]  = wb_data[p*DW +: DW];
              cm_d[r*DW +: DW]  = '1;
            end
          end
        end
      end
    end
    if (flags_en) begin
      cd_d[NREGS*DW +: FW] = wb_flags;
      cm_d[NREGS*DW +: FW] = '1;
    end
    if (ld_merge || ld_alone || hold_commit) begin
      for (int r = 0; r < NREGS; r++) begin
        if (lsel_reg == RW'(r)) begin
          if (hit[r]) begin
            conflict = 1'b1;
          end else begin
            hit[r]           = 1'b1;
            cd_d[r*DW +: DW] = lsel_data;
            cm_d[r*DW +: DW] = '1;
          end
        end
      end
    end
  end

  assign wb_conflict = conflict;

  assign cv_d = core_act | ld_alone | hold_commit;

  always_comb begin
    ca_d = wb_thread;
    if (ld_alone) begin
      ca_d = pt_out;
    end else if (hold_commit) begin
      ca_d = hold_t_q;
    end
  end

  always_comb begin
    hold_v_d = hold_v_q;
    if (hold_commit) begin
      hold_v_d = 1'b0;
    end
    if (to_hold) begin
      hold_v_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Capture with forwarding of the in-flight commit for the same thread.
  // --------------------------------------------------------------------------
  assign rd_raw = ctx_q[thread_load];
  assign rd_fwd = (cv_q && (ca_q == thread_load)) ? ((rd_raw & ~cm_q) | cd_q)
                                                  : rd_raw;

  assign regs     = rd_q[NREGS*DW-1:0];
  assign au_flags = rd_q[NREGS*DW +: FW];

  // --------------------------------------------------------------------------
  // Control state with reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      cv_q      <= 1'b0;
      hold_v_q  <= 1'b0;
      ld_v_q    <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cv_q      <= cv_d;
      hold_v_q  <= hold_v_d;
      if (pipe_adv) begin
        ld_v_q[0] <= accept;
        for (int i = 1; i < LD_DELAY; i++) begin
          ld_v_q[i] <= ld_v_q[i-1];
        end
      end
      if (run && thread_load_en) begin
        rd_q <= rd_fwd;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers (qualified by the valid bits above)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    ca_q <= ca_d;
    cd_q <= cd_d;
    cm_q <= cm_d;
    if (pipe_adv) begin
      ld_t_q[0] <= ld_thread;
      ld_r_q[0] <= ld_reg;
      ld_d_q[0] <= ld_data;
      for (int i = 1; i < LD_DELAY; i++) begin
        ld_t_q[i] <= ld_t_q[i-1];
        ld_r_q[i] <= ld_r_q[i-1];
        ld_d_q[i] <= ld_d_q[i-1];
      end
    end
    if (to_hold) begin
      hold_t_q <= pt_out;
      hold_r_q <= pr_out;
      hold_d_q <= pd_out;
    end
  end

  // Context array: cleared one thread per cycle in INIT, masked update in RUN.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      ctx_q[clr_cnt_q] <= '0;
    end else if (cv_q) begin
      ctx_q[ca_q] <= (ctx_q[ca_q] & ~cm_q) | cd_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tawas_regfile_mt.sv
`default_nettype none
// ============================================================================
// Module   : tb_tawas_regfile_mt
// Purpose  : Self-checking bench for tawas_regfile_mt (THREADS=8, LD_DELAY=2).
//            Table of writeback vectors, directed multi-cycle sequences and a
//            randomized phase checked against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tawas_regfile_mt;

  localparam int THREADS  = 8;
  localparam int NREGS    = 8;
  localparam int DW       = 32;
  localparam int FW       = 8;
  localparam int WB_PORTS = 3;
  localparam int LD_DELAY = 2;
  localparam int TW       = 3;
  localparam int RW       = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   init_done;
  logic                   thread_load_en;
  logic [TW-1:0]          thread_load;
  logic [NREGS*DW-1:0]    regs;
  logic [FW-1:0]          au_flags;
  logic [TW-1:0]          wb_thread;
  logic [WB_PORTS-1:0]    wb_en;
  logic [WB_PORTS*RW-1:0] wb_reg;
  logic [WB_PORTS*DW-1:0] wb_data;
  logic                   wb_flags_en;
  logic [FW-1:0]          wb_flags;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [TW-1:0]          ld_thread;
  logic [RW-1:0]          ld_reg;
  logic [DW-1:0]          ld_data;
  logic                   wb_conflict;

  always #5 clk = ~clk;

  tawas_regfile_mt #(
    .THREADS (THREADS),
    .NREGS   (NREGS),
    .DW      (DW),
    .FW      (FW),
    .WB_PORTS(WB_PORTS),
    .LD_DELAY(LD_DELAY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .init_done     (init_done),
    .thread_load_en(thread_load_en),
    .thread_load   (thread_load),
    .regs          (regs),
    .au_flags      (au_flags),
    .wb_thread     (wb_thread),
    .wb_en         (wb_en),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .wb_flags_en   (wb_flags_en),
    .wb_flags      (wb_flags),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_thread     (ld_thread),
    .ld_reg        (ld_reg),
    .ld_data       (ld_data),
    .wb_conflict   (wb_conflict)
  );

  typedef struct {
    logic [2:0]  thr;
    logic [2:0]  en;
    logic [2:0]  r0, r1, r2;
    logic [31:0] d0, d1, d2;
    logic        fen;
    logic [7:0]  fl;
    logic        conf;
    int          ca;
    logic [31:0] ea;
    int          cb;
    logic [31:0] eb;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model of architectural state.
  logic [31:0] m_reg [THREADS][NREGS];
  logic [7:0]  m_flg [THREADS];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    thread_load_en = 1'b0;
    thread_load    = '0;
    wb_thread      = '0;
    wb_en          = '0;
    wb_reg         = '0;
    wb_data        = '0;
    wb_flags_en    = 1'b0;
    wb_flags       = '0;
    ld_valid       = 1'b0;
    ld_thread      = '0;
    ld_reg         = '0;
    ld_data        = '0;
  endtask

  function automatic logic [31:0] word(input int i);
    if (i == NREGS) return {24'd0, au_flags};
    return regs[i*DW +: DW];
  endfunction

  task automatic read_thr(input int t);
    thread_load_en = 1'b1;
    thread_load    = TW'(t);
    cyc();
    thread_load_en = 1'b0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 100) begin
      cyc();
      n++;
    end
    chk("init_cycles", 256'(n), 256'(THREADS));
  endtask

  task automatic core_wr(input int t, input int r, input logic [31:0] d);
    wb_thread = TW'(t);
    wb_en     = 3'b001;
    wb_reg    = {3'd0, 3'd0, RW'(r)};
    wb_data   = {32'd0, 32'd0, d};
  endtask

  task automatic model_clear();
    for (int t = 0; t < THREADS; t++) begin
      m_flg[t] = '0;
      for (int r = 0; r < NREGS; r++) m_reg[t][r] = '0;
    end
  endtask

  task automatic check_all(input string nm);
    logic [255:0] ev;
    for (int t = 0; t < THREADS; t++) begin
      read_thr(t);
      for (int r = 0; r < NREGS; r++) ev[r*DW +: DW] = m_reg[t][r];
      chk($sformatf("%s_t%0d_regs", nm, t), 256'(regs), ev);
      chk($sformatf("%s_t%0d_flags", nm, t), 256'(au_flags), 256'(m_flg[t]));
    end
  endtask

  initial begin
    vec_t        tbl [6];
    logic [2:0]  en;
    logic [2:0]  rr [3];
    logic [31:0] dd [3];
    logic        ec, rd, acc, fen;
    logic [7:0]  fl;
    logic [2:0]  rt, wt;
    logic [255:0] ev;
    logic [7:0]  ef;
    logic        done_r [NREGS];

    tbl[0] = '{thr:3'd3, en:3'b011, r0:3'd5, r1:3'd5, r2:3'd0, d0:32'hAAAA_0001,
               d1:32'hBBBB_0002, d2:32'h0, fen:1'b0, fl:8'h0, conf:1'b1,
               ca:5, ea:32'hAAAA_0001, cb:0, eb:32'h0};
    tbl[1] = '{thr:3'd3, en:3'b101, r0:3'd1, r1:3'd1, r2:3'd2, d0:32'h1111_0001,
               d1:32'hDEAD_0000, d2:32'h2222_0002, fen:1'b0, fl:8'h0, conf:1'b0,
               ca:1, ea:32'h1111_0001, cb:2, eb:32'h2222_0002};
    tbl[2] = '{thr:3'd5, en:3'b111, r0:3'd0, r1:3'd0, r2:3'd0, d0:32'h10,
               d1:32'h20, d2:32'h30, fen:1'b0, fl:8'h0, conf:1'b1,
               ca:0, ea:32'h10, cb:1, eb:32'h0};
    tbl[3] = '{thr:3'd5, en:3'b110, r0:3'd3, r1:3'd7, r2:3'd7, d0:32'h33,
               d1:32'h77, d2:32'h88, fen:1'b0, fl:8'h0, conf:1'b1,
               ca:7, ea:32'h77, cb:3, eb:32'h0};
    tbl[4] = '{thr:3'd2, en:3'b100, r0:3'd6, r1:3'd6, r2:3'd6, d0:32'h1,
               d1:32'h2, d2:32'hCAFE, fen:1'b0, fl:8'h0, conf:1'b0,
               ca:6, ea:32'hCAFE, cb:5, eb:32'h0};
    tbl[5] = '{thr:3'd0, en:3'b000, r0:3'd0, r1:3'd0, r2:3'd0, d0:32'h5,
               d1:32'h6, d2:32'h7, fen:1'b1, fl:8'h5A, conf:1'b0,
               ca:8, ea:32'h5A, cb:0, eb:32'h0};

    // ---------------- reset and clear sequence ----------------
    idle();
    rst = 1'b1;
    cyc(); cyc(); cyc();
    chk("rst_init_done", 256'(init_done), 256'(0));
    chk("rst_ld_ready", 256'(ld_ready), 256'(0));
    chk("rst_regs", 256'(regs), 256'(0));
    chk("rst_flags", 256'(au_flags), 256'(0));
    @(negedge clk);
    chk("rst_conflict", 256'(wb_conflict), 256'(0));
    cyc();
    rst = 1'b0;
    wait_init();
    chk("init_ld_ready", 256'(ld_ready), 256'(1));
    read_thr(2);
    chk("init_t2_regs", 256'(regs), 256'(0));
    chk("init_t2_flags", 256'(au_flags), 256'(0));

    // ---------------- table-driven writeback vectors ----------------
    for (int k = 0; k < 6; k++) begin
      wb_thread   = tbl[k].thr;
      wb_en       = tbl[k].en;
      wb_reg      = {tbl[k].r2, tbl[k].r1, tbl[k].r0};
      wb_data     = {tbl[k].d2, tbl[k].d1, tbl[k].d0};
      wb_flags_en = tbl[k].fen;
      wb_flags    = tbl[k].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_conflict", k), 256'(wb_conflict), 256'(tbl[k].conf));
      cyc();
      idle();
      @(negedge clk);
      chk($sformatf("vec%0d_conflict_clear", k), 256'(wb_conflict), 256'(0));
      cyc();
      read_thr(int'(tbl[k].thr));
      chk($sformatf("vec%0d_a", k), 256'(word(tbl[k].ca)), 256'(tbl[k].ea));
      chk($sformatf("vec%0d_b", k), 256'(word(tbl[k].cb)), 256'(tbl[k].eb));
    end

    // ---------------- forwarding ----------------
    core_wr(7, 0, 32'h1234_5678);
    thread_load_en = 1'b1;
    thread_load    = 3'd7;
    cyc();
    chk("fwd_same_cycle_old", 256'(word(0)), 256'(0));
    core_wr(7, 0, 32'h9999_0000);
    cyc();
    chk("fwd_next_cycle", 256'(word(0)), 256'(32'h1234_5678));
    idle();
    read_thr(7);
    chk("fwd_second", 256'(word(0)), 256'(32'h9999_0000));

    // ---------------- hold buffering ----------------
    idle();
    ld_valid  = 1'b1;
    ld_thread = 3'd4;
    ld_reg    = 3'd3;
    ld_data   = 32'hDEAD_BEEF;
    core_wr(1, 0, 32'h100);
    @(negedge clk);
    chk("hold_accept_ready", 256'(ld_ready), 256'(1));
    cyc();
    ld_valid = 1'b0;
    for (int k = 1; k < 6; k++) begin
      core_wr(1, k, 32'h100 + 32'(k));
      if (k >= 3) begin
        @(negedge clk);
        chk($sformatf("hold_full_ready_c%0d", k), 256'(ld_ready), 256'(0));
      end
      cyc();
    end
    idle();
    thread_load_en = 1'b1;
    thread_load    = 3'd4;
    cyc();
    chk("hold_read_before_commit", 256'(word(3)), 256'(0));
    @(negedge clk);
    chk("hold_drained_ready", 256'(ld_ready), 256'(1));
    cyc();
    chk("hold_commit_value", 256'(word(3)), 256'(32'hDEAD_BEEF));
    thread_load_en = 1'b0;
    read_thr(1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("hold_t1_r%0d", k), 256'(word(k)), 256'(32'h100 + 32'(k)));
    end

    // ---------------- load vs core, same thread ----------------
    for (int s = 0; s < 2; s++) begin
      idle();
      ld_valid  = 1'b1;
      ld_thread = 3'd6;
      ld_reg    = (s == 0) ? 3'd2 : 3'd4;
      ld_data   = (s == 0) ? 32'h0BAD : 32'h4444;
      cyc();
      idle();
      cyc();
      core_wr(6, 2, (s == 0) ? 32'hC0DE : 32'h2222);
      @(negedge clk);
      chk($sformatf("ldcore%0d_conflict", s), 256'(wb_conflict), 256'(s == 0));
      cyc();
      idle();
      @(negedge clk);
      chk($sformatf("ldcore%0d_ready", s), 256'(ld_ready), 256'(1));
      thread_load_en = 1'b1;
      thread_load    = 3'd6;
      cyc();
      thread_load_en = 1'b0;
      if (s == 0) begin
        chk("ldcore0_reg2", 256'(word(2)), 256'(32'hC0DE));
      end else begin
        chk("ldcore1_reg4", 256'(word(4)), 256'(32'h4444));
        chk("ldcore1_reg2", 256'(word(2)), 256'(32'h2222));
      end
    end

    // ---------------- reset with hold full and pipeline busy ----------------
    idle();
    ld_valid = 1'b1; ld_thread = 3'd4; ld_reg = 3'd1; ld_data = 32'hAAAA;
    cyc();
    ld_thread = 3'd5; ld_data = 32'hBBBB;
    core_wr(0, 0, 32'h1);
    cyc();
    ld_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("rstmid_hold_full", 256'(ld_ready), 256'(0));
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    idle();
    rst = 1'b0;
    wait_init();
    for (int k = 0; k < 6; k++) cyc();
    model_clear();
    check_all("rstmid");

    // ---------------- randomized phase vs reference model ----------------
    for (int c = 0; c < 400; c++) begin
      idle();
      wt = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 3) begin
        en  = 3'b000;
        fen = 1'b0;
      end else begin
        en  = 3'($urandom);
        fen = ($urandom_range(0, 3) == 0);
      end
      fl = 8'($urandom);
      for (int p = 0; p < 3; p++) begin
        rr[p] = 3'($urandom_range(0, 7));
        dd[p] = $urandom;
      end
      wb_thread   = wt;
      wb_en       = en;
      wb_reg      = {rr[2], rr[1], rr[0]};
      wb_data     = {dd[2], dd[1], dd[0]};
      wb_flags_en = fen;
      wb_flags    = fl;
      ld_valid    = 1'($urandom_range(0, 1));
      ld_thread   = 3'(4 + $urandom_range(0, 3));
      ld_reg      = 3'($urandom_range(0, 7));
      ld_data     = $urandom;
      rd          = ($urandom_range(0, 2) == 0);
      rt          = 3'($urandom_range(0, 3));
      thread_load_en = rd;
      thread_load    = rt;
      ec = 1'b0;
      for (int p = 0; p < 3; p++)
        for (int q = 0; q < p; q++)
          if (en[p] && en[q] && rr[p] == rr[q]) ec = 1'b1;
      for (int r = 0; r < NREGS; r++) ev[r*DW +: DW] = m_reg[rt][r];
      ef = m_flg[rt];
      @(negedge clk);
      chk($sformatf("rand%0d_conflict", c), 256'(wb_conflict), 256'(ec));
      acc = ld_valid && ld_ready;
      for (int r = 0; r < NREGS; r++) done_r[r] = 1'b0;
      for (int p = 0; p < 3; p++) begin
        if (en[p] && !done_r[rr[p]]) begin
          m_reg[wt][rr[p]] = dd[p];
          done_r[rr[p]]    = 1'b1;
        end
      end
      if (fen) m_flg[wt] = fl;
      if (acc) m_reg[ld_thread][ld_reg] = ld_data;
      cyc();
      if (rd) begin
        chk($sformatf("rand%0d_regs", c), 256'(regs), ev);
        chk($sformatf("rand%0d_flags", c), 256'(au_flags), 256'(ef));
      end
    end
    idle();
    for (int k = 0; k < 20; k++) cyc();
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
